// File: rtl/module_split_if_pkg.sv
// Shared definitions for the word splitter: FSM states, field geometry and
// field extraction helpers for the packed 16-bit input word.
package module_split_if_pkg;

    localparam int unsigned WORD_W = 16;

    localparam int unsigned A_W = 4;
    localparam int unsigned B_W = 4;
    localparam int unsigned C_W = 8;

    localparam int unsigned A_LSB = 12;
    localparam int unsigned B_LSB = 8;
    localparam int unsigned C_LSB = 0;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_e;

    function automatic logic [A_W-1:0] field_a(input logic [WORD_W-1:0] word);
        return word[A_LSB +: A_W];
    endfunction

    function automatic logic [B_W-1:0] field_b(input logic [WORD_W-1:0] word);
        return word[B_LSB +: B_W];
    endfunction

    function automatic logic [C_W-1:0] field_c(input logic [WORD_W-1:0] word);
        return word[C_LSB +: C_W];
    endfunction

endpackage

// File: rtl/module_split_if.sv
// Word splitter: accepts a packed {a,b,c} word and emits it as one byte (c)
// or two bytes ({a,b} then c) depending on the mode sampled with the word.
// Counts fully emitted words.
module module_split_if
    import module_split_if_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        in_word,
    input  logic               in_cond_if,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_a,
    output logic [3:0]         out_b,
    output logic [7:0]         out_c,
    output logic [7:0]         out_byte,
    output logic               out_last,
    output logic [CNT_W-1:0]   out_count
);

    state_e           state_q, state_d;
    logic [A_W-1:0]   a_q, a_d;
    logic [B_W-1:0]   b_q, b_d;
    logic [C_W-1:0]   c_q, c_d;
    logic             cond_q, cond_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             in_hs;
    logic             out_hs;

    assign in_hs  = in_valid && (state_q == IDLE);
    assign out_hs = out_ready && (state_q != IDLE);

    // Next-state, capture and completed-word count
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        cond_d  = cond_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (in_hs) begin
                    a_d     = field_a(in_word);
                    b_d     = field_b(in_word);
                    c_d     = field_c(in_word);
                    cond_d  = in_cond_if;
                    state_d = BEAT0;
                end
            end
            BEAT0: begin
                if (out_hs) begin
                    if (cond_q) begin
                        state_d = IDLE;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else begin
                        state_d = BEAT1;
                    end
                end
            end
            BEAT1: begin
                if (out_hs) begin
                    state_d = IDLE;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Beat payload and handshake outputs decoded from state and captured word
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_byte  = '0;
        out_last  = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            BEAT0: begin
                out_valid = 1'b1;
                if (cond_q) begin
                    out_byte = c_q;
                    out_last = 1'b1;
                end else begin
                    out_byte = {a_q, b_q};
                    out_last = 1'b0;
                end
            end
            BEAT1: begin
                out_valid = 1'b1;
                out_byte  = c_q;
                out_last  = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            cond_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            cond_q  <= cond_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_a     = a_q;
    assign out_b     = b_q;
    assign out_c     = c_q;
    assign out_count = cnt_q;

endmodule

// File: doc/module_split_if.md
MODULE_SPLIT_IF -- requirements
Module: module_split_if

Interface
REQ-001 Parameter: CNT_W, default 8, width of the completed-word counter; SHALL be legal for 1..16.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  packed word offered.
REQ-005 Port: in_ready  output  1  block can accept a word.
REQ-006 Port: in_word  input  16  packed word {a[15:12], b[11:8], c[7:0]}.
REQ-007 Port: in_cond_if  input  1  mode, sampled with in_word: 1 = single-byte emit, 0 = two-byte emit.
REQ-008 Port: out_valid  output  1  output beat present.
REQ-009 Port: out_ready  input  1  consumer accepts beat.
REQ-010 Port: out_a  output  4  captured field a.
REQ-011 Port: out_b  output  4  captured field b.
REQ-012 Port: out_c  output  8  captured field c.
REQ-013 Port: out_byte  output  8  current beat payload.
REQ-014 Port: out_last  output  1  current beat is the final beat of the word.
REQ-015 Port: out_count  output  CNT_W  number of fully emitted words, modulo 2^CNT_W.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, BEAT0, BEAT1.
REQ-017 in_ready SHALL be 1 exactly when the state is IDLE; out_valid SHALL be 1 exactly in BEAT0 or BEAT1.
REQ-018 An input handshake is in_valid && in_ready.
- Capture a, b, c and in_cond_if into registers.
- Go to BEAT0 on the next edge.
REQ-019 BEAT0 beat contents:
- out_byte = c and out_last = 1 when the captured cond is 1.
- out_byte = {a,b} and out_last = 0 when the captured cond is 0.
REQ-020 BEAT1 beat contents: out_byte = c, out_last = 1.
REQ-021 BEAT0 transitions on out_ready:
- To IDLE if cond = 1.
- To BEAT1 if cond = 0.
- No out_ready: remain in BEAT0.
REQ-022 BEAT1 transitions on out_ready:
- To IDLE.
- No out_ready: remain in BEAT1.
REQ-023 Stall stability: while out_valid && !out_ready, out_a, out_b, out_c, out_byte and out_last SHALL hold stable.
REQ-024 out_a, out_b and out_c SHALL hold the last captured word until the next input handshake.
REQ-025 Latency: the first output beat SHALL be valid one cycle after the input handshake. No input SHALL be accepted while a word is being emitted.
REQ-026 Throughput: back-to-back words SHALL take 2 cycles each for cond = 1 and 3 cycles each for cond = 0.
REQ-027 out_count SHALL increment by 1 on the handshake of each out_last beat.
- Wraps from 2^CNT_W-1 to 0.
- Visible the cycle after that handshake.
REQ-028 in_word and in_cond_if SHALL be ignored when no input handshake occurs.
REQ-029 out_ready while out_valid = 0 SHALL have no effect.

Reset
REQ-030 Assertion of rst_n = 0 SHALL immediately (asynchronously) force the following, regardless of clk:
- State = IDLE.
- Captured fields, cond, out_a, out_b, out_c, out_byte, out_last and out_count all 0.
REQ-031 During reset, out_valid SHALL be 0 and in_ready SHALL be 1.
REQ-032 Reset asserted mid-word (BEAT0 or BEAT1) SHALL discard the word without incrementing out_count.
REQ-033 The first handshake SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-034 A shared package module_split_if_pkg SHALL hold the following:
- The state enum (IDLE, BEAT0, BEAT1).
- Field widths (A_W=4, B_W=4, C_W=8).
- Field bit offsets within the 16-bit word.
REQ-035 The block SHALL be a single module with no sub-modules; the FSM and datapath registers SHALL reside in one file.

Verification
REQ-036 in_word=16'hA5C3, cond=1, out_ready=1 -> next cycle: out_valid=1, out_byte=8'hC3, out_last=1, out_a=4'hA, out_b=4'h5; following cycle: out_count=1, in_ready=1.
REQ-037 in_word=16'h3C7E, cond=0, out_ready=1 -> beats 8'h3C (last=0) then 8'h7E (last=1); out_count +1 only after the second beat.
REQ-038 cond=0 word with out_ready held 0 for 4 cycles in BEAT0 and again in BEAT1 -> out_byte and out_last stable throughout, in_ready=0, and a new in_valid with a different word is ignored.
REQ-039 CNT_W=2, 5 cond=1 words -> out_count sequence 1, 2, 3, 0, 1.
REQ-040 rst_n pulsed low mid-BEAT1 -> immediate out_valid=0 and out_count=0; in_ready=1 while reset is held and after release; the next word is emitted correctly.
